// File: rtl/bouncing_ball_pkg.sv
// Shared types and edge/clamp helpers for the frame-stepped ball engine.
// Edge math is 14-bit signed so off-screen positions stay representable.
package bouncing_ball_pkg;

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_WALL, S_PADDLE, S_COMMIT} state_e;

  localparam int WALL_TOP    = 3;
  localparam int WALL_BOTTOM = 2;
  localparam int WALL_RIGHT  = 1;
  localparam int WALL_LEFT   = 0;

  typedef logic signed [13:0] edge_t;
  typedef logic signed [12:0] vel_t;

  typedef struct packed {
    edge_t top;
    edge_t bottom;
    edge_t left;
    edge_t right;
  } rect_t;

  function automatic edge_t to_edge(input logic [12:0] u);
    return edge_t'({1'b0, u});
  endfunction

  function automatic edge_t vel_ext(input vel_t v);
    return edge_t'({v[12], v});
  endfunction

  function automatic edge_t edge_lo(input edge_t c, input edge_t s);
    return c - (s >>> 1);
  endfunction

  function automatic edge_t edge_hi(input edge_t c, input edge_t s);
    return c + ((s - 14'sd1) >>> 1);
  endfunction

  function automatic rect_t make_rect(input edge_t row, input edge_t col,
                                      input edge_t h, input edge_t w);
    rect_t r;
    r.top    = edge_lo(row, h);
    r.bottom = edge_hi(row, h);
    r.left   = edge_lo(col, w);
    r.right  = edge_hi(col, w);
    return r;
  endfunction

  function automatic vel_t vel_pos(input vel_t v);
    return v[12] ? -v : v;
  endfunction

  function automatic vel_t vel_neg(input vel_t v);
    return v[12] ? v : -v;
  endfunction

  function automatic logic below_lo(input edge_t c, input edge_t size);
    return edge_lo(c, size) < 14'sd0;
  endfunction

  function automatic logic above_hi(input edge_t c, input edge_t size, input edge_t lim);
    return edge_hi(c, size) >= lim;
  endfunction

  // Low-side violation wins when both edges are out, matching the wall rule order.
  function automatic edge_t clamp_pos(input edge_t c, input edge_t size, input edge_t lim);
    if (below_lo(c, size))           return size >>> 1;
    else if (above_hi(c, size, lim)) return lim - 14'sd1 - ((size - 14'sd1) >>> 1);
    else                             return c;
  endfunction

  function automatic vel_t clamp_vel(input edge_t c, input vel_t v,
                                     input edge_t size, input edge_t lim);
    if (below_lo(c, size))           return vel_pos(v);
    else if (above_hi(c, size, lim)) return vel_neg(v);
    else                             return v;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic inc);
    return (inc && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
  endfunction

endpackage

// File: rtl/bouncing_ball_if.sv
// Paddle-stage to ball-engine link: frame strobe and paddle in, ball state and events out.
interface bouncing_ball_if;
  logic        active;
  logic        newFrame;
  logic [12:0] pRow;
  logic [12:0] pCol;
  logic [12:0] pH;
  logic [12:0] pW;
  logic [12:0] bRow;
  logic [12:0] bCol;
  logic [12:0] bSize;
  logic [3:0]  hitWall;
  logic        hitPaddle;
  logic [7:0]  hitCount;
  logic        busy;
  logic        overrun;

  modport master (
    output active, newFrame, pRow, pCol, pH, pW,
    input  bRow, bCol, bSize, hitWall, hitPaddle, hitCount, busy, overrun
  );

  modport slave (
    input  active, newFrame, pRow, pCol, pH, pW,
    output bRow, bCol, bSize, hitWall, hitPaddle, hitCount, busy, overrun
  );
endinterface

// File: rtl/bouncing_ball_rect_overlap.sv
// Combinational inclusive-edge overlap test between two rectangles.
module rect_overlap
  import bouncing_ball_pkg::*;
(
  input  rect_t a_i,
  input  rect_t b_i,
  output logic  hit_o
);
  assign hit_o = (a_i.left <= b_i.right) && (a_i.right  >= b_i.left) &&
                 (a_i.top  <= b_i.bottom) && (a_i.bottom >= b_i.top);
endmodule

// File: rtl/bouncing_ball.sv
// Ball engine: one pass IDLE->STEP->WALL->PADDLE->COMMIT per accepted frame strobe.
// Ball outputs and hit pulses change only in COMMIT; reset aborts a frame in flight.
module bouncing_ball
  import bouncing_ball_pkg::*;
#(
  parameter int BALL_SIZE = 10,
  parameter int COLS      = 640,
  parameter int ROWS      = 480,
  parameter int INIT_VH   = 2,
  parameter int INIT_VV   = 2
) (
  input  logic            clk,
  input  logic            reset,
  bouncing_ball_if.slave  ball_if
);

  localparam edge_t BS     = edge_t'(BALL_SIZE);
  localparam edge_t COLS_E = edge_t'(COLS);
  localparam edge_t ROWS_E = edge_t'(ROWS);

  state_e      state_q;
  logic [12:0] bRow_q, bCol_q;
  vel_t        vH_q, vV_q;
  logic [12:0] pRow_q, pCol_q, pH_q, pW_q;
  edge_t       prevRow_q, prevCol_q;
  edge_t       nRow_q, nCol_q;
  logic [3:0]  wall_q;
  logic        hit_q;
  logic [3:0]  hitWall_q;
  logic        hitPaddle_q;
  logic [7:0]  hitCount_q;
  logic        overrun_q;

  edge_t step_row_d, step_col_d;
  edge_t pad_row_d, pad_col_d;
  vel_t  pad_vh_d, pad_vv_d;
  rect_t ball_rect, pad_rect;
  logic  overlap;

  assign ball_rect = make_rect(nRow_q, nCol_q, BS, BS);
  assign pad_rect  = make_rect(to_edge(pRow_q), to_edge(pCol_q), to_edge(pH_q), to_edge(pW_q));

  rect_overlap u_overlap (
    .a_i   (ball_rect),
    .b_i   (pad_rect),
    .hit_o (overlap)
  );

  // Side selection uses the pre-move centre so a paddle sliding onto the ball still resolves.
  always_comb begin
    step_row_d = to_edge(bRow_q) + vel_ext(vV_q);
    step_col_d = to_edge(bCol_q) + vel_ext(vH_q);
    pad_row_d  = nRow_q;
    pad_col_d  = nCol_q;
    pad_vh_d   = vH_q;
    pad_vv_d   = vV_q;
    if (overlap) begin
      if (prevCol_q < pad_rect.left) begin
        pad_col_d = pad_rect.left - 14'sd1 - ((BS - 14'sd1) >>> 1);
        pad_vh_d  = vel_neg(vH_q);
      end else if (prevCol_q > pad_rect.right) begin
        pad_col_d = pad_rect.right + 14'sd1 + (BS >>> 1);
        pad_vh_d  = vel_pos(vH_q);
      end else if (prevRow_q < pad_rect.top) begin
        pad_row_d = pad_rect.top - 14'sd1 - ((BS - 14'sd1) >>> 1);
        pad_vv_d  = vel_neg(vV_q);
      end else begin
        pad_row_d = pad_rect.bottom + 14'sd1 + (BS >>> 1);
        pad_vv_d  = vel_pos(vV_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bRow_q      <= 13'(ROWS / 2);
      bCol_q      <= 13'(COLS / 2);
      vH_q        <= vel_t'(INIT_VH);
      vV_q        <= vel_t'(INIT_VV);
      hitWall_q   <= '0;
      hitPaddle_q <= 1'b0;
      hitCount_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      hitWall_q   <= '0;
      hitPaddle_q <= 1'b0;
      if (ball_if.newFrame && state_q != S_IDLE) overrun_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (ball_if.newFrame && ball_if.active) begin
            pRow_q    <= ball_if.pRow;
            pCol_q    <= ball_if.pCol;
            pH_q      <= ball_if.pH;
            pW_q      <= ball_if.pW;
            prevRow_q <= to_edge(bRow_q);
            prevCol_q <= to_edge(bCol_q);
            state_q   <= S_STEP;
          end
        end
        S_STEP: begin
          nRow_q  <= step_row_d;
          nCol_q  <= step_col_d;
          state_q <= S_WALL;
        end
        S_WALL: begin
          nCol_q  <= clamp_pos(nCol_q, BS, COLS_E);
          vH_q    <= clamp_vel(nCol_q, vH_q, BS, COLS_E);
          nRow_q  <= clamp_pos(nRow_q, BS, ROWS_E);
          vV_q    <= clamp_vel(nRow_q, vV_q, BS, ROWS_E);
          wall_q[WALL_LEFT]   <= below_lo(nCol_q, BS);
          wall_q[WALL_RIGHT]  <= !below_lo(nCol_q, BS) && above_hi(nCol_q, BS, COLS_E);
          wall_q[WALL_TOP]    <= below_lo(nRow_q, BS);
          wall_q[WALL_BOTTOM] <= !below_lo(nRow_q, BS) && above_hi(nRow_q, BS, ROWS_E);
          state_q <= S_PADDLE;
        end
        S_PADDLE: begin
          nRow_q  <= pad_row_d;
          nCol_q  <= pad_col_d;
          vH_q    <= pad_vh_d;
          vV_q    <= pad_vv_d;
          hit_q   <= overlap;
          state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          bRow_q      <= 13'(clamp_pos(nRow_q, BS, ROWS_E));
          bCol_q      <= 13'(clamp_pos(nCol_q, BS, COLS_E));
          vV_q        <= clamp_vel(nRow_q, vV_q, BS, ROWS_E);
          vH_q        <= clamp_vel(nCol_q, vH_q, BS, COLS_E);
          hitWall_q   <= wall_q;
          hitPaddle_q <= hit_q;
          hitCount_q  <= sat_inc(hitCount_q, hit_q);
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ball_if.bRow      = bRow_q;
  assign ball_if.bCol      = bCol_q;
  assign ball_if.bSize     = 13'(BALL_SIZE);
  assign ball_if.hitWall   = hitWall_q;
  assign ball_if.hitPaddle = hitPaddle_q;
  assign ball_if.hitCount  = hitCount_q;
  assign ball_if.busy      = (state_q != S_IDLE);
  assign ball_if.overrun   = overrun_q;

endmodule
